// File: rtl/page_transfer_arbiter_pkg.sv
// Shared types for the page transfer arbiter.
// Holds the arbiter FSM encoding and the QSPI address width.
package page_transfer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam int QSPI_ADDRESS_SIZE = 24;

endpackage

// File: rtl/page_rr_picker.sv
// Combinational round-robin pick: the first set bit of req, scanning upward from pointer
// and wrapping around. PAGE_COUNT must be a power of two so the index add wraps for free.
module page_rr_picker #(
  parameter int PAGE_COUNT = 16,
  parameter int INDEX_SIZE = $clog2(PAGE_COUNT)
) (
  input  logic [PAGE_COUNT-1:0] req,
  input  logic [INDEX_SIZE-1:0] pointer,
  output logic                  valid,
  output logic [INDEX_SIZE-1:0] index
);

  logic [INDEX_SIZE-1:0] cand_index [PAGE_COUNT];
  logic [PAGE_COUNT-1:0] cand_req;

  // Candidate gi is the page gi positions after the pointer.
  for (genvar gi = 0; gi < PAGE_COUNT; gi++) begin : g_rotate
    assign cand_index[gi] = pointer + INDEX_SIZE'(gi);
    assign cand_req[gi]   = req[cand_index[gi]];
  end

  always_comb begin
    valid = |req;
    index = '0;
    for (int k = PAGE_COUNT - 1; k >= 0; k--) begin
      if (cand_req[k]) index = cand_index[k];
    end
  end

endmodule

// File: rtl/page_transfer_arbiter.sv
// Grants the single QSPI transfer engine to one cache page at a time and muxes that
// page's address/strobes onto the engine until its whole transfer has finished.
module page_transfer_arbiter
  import page_transfer_arbiter_pkg::*;
#(
  parameter int PAGE_COUNT = 16,
  parameter int INDEX_SIZE = $clog2(PAGE_COUNT)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    qspi_enable,
  input  logic                                    qspi_initialised,
  input  logic                                    qspi_busy,
  input  logic [PAGE_COUNT-1:0]                   page_requestData,
  input  logic [PAGE_COUNT-1:0]                   page_storeData,
  input  logic [PAGE_COUNT-1:0]                   page_changeAddress,
  input  logic [PAGE_COUNT*QSPI_ADDRESS_SIZE-1:0] page_address,
  input  logic                                    urgentValid,
  input  logic [INDEX_SIZE-1:0]                   urgentIndex,
  output logic [PAGE_COUNT-1:0]                   pageLoading,
  output logic [PAGE_COUNT-1:0]                   pageFlushing,
  output logic [QSPI_ADDRESS_SIZE-1:0]            qspi_address,
  output logic                                    qspi_changeAddress,
  output logic                                    qspi_requestData,
  output logic                                    qspi_storeData,
  output logic [INDEX_SIZE-1:0]                   activeIndex,
  output logic                                    active
);

  arb_state_t            state;
  logic [INDEX_SIZE-1:0] rr_pointer;
  logic                  active_flush;
  logic [PAGE_COUNT-1:0] req;
  logic                  pick_valid;
  logic [INDEX_SIZE-1:0] pick_index;
  logic                  urgent_hit;
  logic [INDEX_SIZE-1:0] winner;
  logic                  release_ok;

  assign req = page_requestData | page_storeData;

  page_rr_picker #(
    .PAGE_COUNT(PAGE_COUNT),
    .INDEX_SIZE(INDEX_SIZE)
  ) u_picker (
    .req    (req),
    .pointer(rr_pointer),
    .valid  (pick_valid),
    .index  (pick_index)
  );

  assign urgent_hit = urgentValid && req[urgentIndex];
  assign winner     = urgent_hit ? urgentIndex : pick_index;

  // A dropped request, a load/flush flip or a disabled block ends the grant,
  // but never while the engine is still mid-transaction.
  assign release_ok = (!req[activeIndex] || (page_storeData[activeIndex] != active_flush) ||
                       !qspi_enable) && !qspi_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_pointer   <= '0;
      active_flush <= 1'b0;
      activeIndex  <= '0;
      active       <= 1'b0;
      pageLoading  <= '0;
      pageFlushing <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (qspi_enable && qspi_initialised && pick_valid) begin
            activeIndex  <= winner;
            active_flush <= page_storeData[winner];
            state        <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          pageLoading  <= '0;
          pageFlushing <= '0;
          if (active_flush) pageFlushing[activeIndex] <= 1'b1;
          else              pageLoading[activeIndex]  <= 1'b1;
          active <= 1'b1;
          state  <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (release_ok) begin
            pageLoading  <= '0;
            pageFlushing <= '0;
            active       <= 1'b0;
            rr_pointer   <= activeIndex + 1'b1;
            state        <= ST_RELEASE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    qspi_address       = '0;
    qspi_changeAddress = 1'b0;
    qspi_requestData   = 1'b0;
    qspi_storeData     = 1'b0;
    if (active) begin
      qspi_address       = page_address[QSPI_ADDRESS_SIZE*activeIndex +: QSPI_ADDRESS_SIZE];
      qspi_changeAddress = page_changeAddress[activeIndex];
      qspi_requestData   = !active_flush;
      qspi_storeData     = active_flush;
    end
  end

endmodule

// File: tb/tb_page_transfer_arbiter.sv
// Directed bench for page_transfer_arbiter: a cycle model of the grant rules is checked
// against the DUT on every falling edge, plus literal expectations per scenario.
module tb_page_transfer_arbiter;

  localparam int PC = 16;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            qspi_enable = 1'b1;
  logic            qspi_initialised = 1'b1;
  logic            qspi_busy = 1'b0;
  logic [PC-1:0]   rd = '0;
  logic [PC-1:0]   sd = '0;
  logic [PC-1:0]   ca = '0;
  logic [PC*24-1:0] addr;
  logic            uv = 1'b0;
  logic [IW-1:0]   ui = '0;

  logic [PC-1:0]   pageLoading, pageFlushing;
  logic [23:0]     qspi_address;
  logic            qspi_changeAddress, qspi_requestData, qspi_storeData;
  logic [IW-1:0]   activeIndex;
  logic            active;

  int n_compared = 0;
  int n_mismatch = 0;

  always #5 clk = ~clk;

  page_transfer_arbiter #(.PAGE_COUNT(PC), .INDEX_SIZE(IW)) dut (
    .clk               (clk),
    .rst               (rst),
    .qspi_enable       (qspi_enable),
    .qspi_initialised  (qspi_initialised),
    .qspi_busy         (qspi_busy),
    .page_requestData  (rd),
    .page_storeData    (sd),
    .page_changeAddress(ca),
    .page_address      (addr),
    .urgentValid       (uv),
    .urgentIndex       (ui),
    .pageLoading       (pageLoading),
    .pageFlushing      (pageFlushing),
    .qspi_address      (qspi_address),
    .qspi_changeAddress(qspi_changeAddress),
    .qspi_requestData  (qspi_requestData),
    .qspi_storeData    (qspi_storeData),
    .activeIndex       (activeIndex),
    .active            (active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // grant_page: page whose grant is visible (-1 none); chosen_page: picked, visible next cycle;
  // gap: the single dead cycle after a release.
  int grant_page = -1;
  bit grant_flush = 1'b0;
  int chosen_page = -1;
  bit chosen_flush = 1'b0;
  bit gap = 1'b0;
  int ptr = 0;
  int model_order[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_page = -1; chosen_page = -1; gap = 1'b0; ptr = 0; grant_flush = 1'b0;
    end else if (grant_page >= 0) begin
      bit want;
      want = rd[grant_page] | sd[grant_page];
      if ((!want || (sd[grant_page] != grant_flush) || !qspi_enable) && !qspi_busy) begin
        ptr = (grant_page + 1) % PC;
        grant_page = -1;
        gap = 1'b1;
      end
    end else if (chosen_page >= 0) begin
      grant_page = chosen_page;
      grant_flush = chosen_flush;
      chosen_page = -1;
      model_order.push_back(grant_page);
    end else if (gap) begin
      gap = 1'b0;
    end else if (qspi_enable && qspi_initialised && ((rd | sd) != '0)) begin
      int w;
      w = -1;
      if (uv && (rd[ui] | sd[ui])) w = int'(ui);
      for (int k = 0; k < PC && w < 0; k++) begin
        int p;
        p = (ptr + k) % PC;
        if (rd[p] | sd[p]) w = p;
      end
      chosen_page = w;
      chosen_flush = sd[w];
    end
  end

  always @(negedge clk) begin
    logic [PC-1:0] e_load, e_flush;
    logic [23:0]   e_addr;
    logic          e_ca;
    e_load = '0; e_flush = '0; e_addr = '0; e_ca = 1'b0;
    if (grant_page >= 0) begin
      if (grant_flush) e_flush[grant_page] = 1'b1;
      else             e_load[grant_page]  = 1'b1;
      e_addr = addr[24*grant_page +: 24];
      e_ca   = ca[grant_page];
      check("activeIndex", 32'(activeIndex), 32'(grant_page));
    end
    check("pageLoading", 32'(pageLoading), 32'(e_load));
    check("pageFlushing", 32'(pageFlushing), 32'(e_flush));
    check("active", 32'(active), 32'(grant_page >= 0));
    check("qspi_address", 32'(qspi_address), 32'(e_addr));
    check("qspi_changeAddress", 32'(qspi_changeAddress), 32'(e_ca));
    check("qspi_requestData", 32'(qspi_requestData), 32'(grant_page >= 0 && !grant_flush));
    check("qspi_storeData", 32'(qspi_storeData), 32'(grant_page >= 0 && grant_flush));
  end

  // ---------------- stimulus ----------------
  task automatic wait_active(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (active) begin ok = 1'b1; break; end
    end
    n_compared++;
    if (!ok) begin
      n_mismatch++;
      $display("FAIL %s: got no grant, expected grant within 24 cycles", name);
    end else begin
      $display("grant page %0d load=%b flush=%b addr=%h", activeIndex,
               |pageLoading, |pageFlushing, qspi_address);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int order[$];
    int start;
    int exp_order[4];
    exp_order = '{2, 3, 9, 2};
    for (int i = 0; i < PC; i++) addr[24*i +: 24] = {8'hA0, 8'(i), 8'(i)};
    cycles(3);
    rst = 1'b0;
    check("reset_active", 32'(active), 32'h0);
    check("reset_loading", 32'(pageLoading), 32'h0);

    // Single load on page 5: two edges of latency, one-cycle release gap.
    rd[5] = 1'b1; ca[5] = 1'b1;
    @(negedge clk);
    check("t2_not_yet", 32'(pageLoading), 32'h0);
    @(negedge clk);
    check("t2_loading", 32'(pageLoading), 32'h0020);
    check("t2_address", 32'(qspi_address), 32'h00A00505);
    check("t2_reqdata", 32'(qspi_requestData), 32'h1);
    $display("grant page 5 load addr=%h", qspi_address);
    #1 rd[5] = 1'b0; ca[5] = 1'b0;
    @(negedge clk);
    check("t2_released", 32'(pageLoading), 32'h0);
    @(negedge clk);
    check("t2_gap", 32'(active), 32'h0);
    cycles(3);

    // Round robin from pointer 0 with 2, 3, 9 requesting.
    do_reset();
    rd[2] = 1'b1; rd[3] = 1'b1; rd[9] = 1'b1;
    start = model_order.size();
    for (int g = 0; g < 4; g++) begin
      int idx;
      wait_active("t3_wait");
      idx = int'(activeIndex);
      order.push_back(idx);
      if (g == 3) break;
      #1 rd[idx] = 1'b0;
      @(negedge clk);
      #1 rd[idx] = 1'b1;
    end
    for (int g = 0; g < 4; g++) begin
      check("t3_dut_order", (g < order.size()) ? 32'(order[g]) : 32'hFFFF_FFFF, 32'(exp_order[g]));
      check("t3_model_order", (start + g < model_order.size()) ? 32'(model_order[start+g]) : 32'hFFFF_FFFF,
            32'(exp_order[g]));
    end

    // Reset in the middle of page 2's grant clears everything immediately.
    #1 rst = 1'b1;
    #1;
    check("t1_loading", 32'(pageLoading), 32'h0);
    check("t1_active", 32'(active), 32'h0);
    check("t1_address", 32'(qspi_address), 32'h0);
    check("t1_reqdata", 32'(qspi_requestData), 32'h0);
    rd = '0;
    cycles(2);
    rst = 1'b0;
    cycles(2);

    // Urgent pick, and no preemption by a later urgent.
    rd[1] = 1'b1; rd[7] = 1'b1; uv = 1'b1; ui = 4'd7;
    wait_active("t4_wait7");
    check("t4_urgent_first", 32'(activeIndex), 32'd7);
    #1 ui = 4'd1;
    cycles(4);
    check("t4_no_preempt", 32'(pageLoading), 32'h0080);
    rd[7] = 1'b0;
    wait_active("t4_wait1");
    check("t4_then_1", 32'(activeIndex), 32'd1);
    #1 rd[1] = 1'b0; uv = 1'b0;
    cycles(4);

    // Busy hold: dropped request kept granted while the engine is busy.
    rd[4] = 1'b1;
    wait_active("t5_wait");
    #1 rd[4] = 1'b0; qspi_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_held", 32'(active), 32'h1);
    end
    #1 qspi_busy = 1'b0;
    @(negedge clk);
    check("t5_released", 32'(active), 32'h0);
    cycles(4);

    // Gating by initialised/enable, flush priority and kind change.
    qspi_initialised = 1'b0; rd[0] = 1'b1;
    cycles(5);
    check("t6_init_gate", 32'(active), 32'h0);
    qspi_initialised = 1'b1;
    wait_active("t6_wait_load");
    check("t6_load", 32'(pageLoading), 32'h0001);
    #1 rd[0] = 1'b0;
    cycles(4);
    qspi_enable = 1'b0; rd[3] = 1'b1;
    cycles(4);
    check("t6_enable_gate", 32'(active), 32'h0);
    qspi_enable = 1'b1;
    wait_active("t6_wait_en");
    check("t6_enable_pick", 32'(activeIndex), 32'd3);
    #1 rd[3] = 1'b0;
    cycles(4);
    rd[0] = 1'b1; sd[0] = 1'b1;
    wait_active("t6_wait_flush");
    check("t6_flush", 32'(pageFlushing), 32'h0001);
    check("t6_flush_noload", 32'(pageLoading), 32'h0);
    check("t6_storedata", 32'(qspi_storeData), 32'h1);
    #1 sd[0] = 1'b0;
    @(negedge clk);
    check("t6_kind_change", 32'(active), 32'h0);
    wait_active("t6_wait_reload");
    check("t6_reload", 32'(pageLoading), 32'h0001);
    #1 rd[0] = 1'b0;
    cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
